// File: rtl/dds_voice.sv
// dds_voice: single-channel multi-waveform DDS oscillator (saw, pulse, triangle, noise)
// with hard sync and a volume scaler. The output is an offset-binary sample with a valid strobe.
// Two-stage pipeline:
//   stage 1 - phase accumulator, LFSR and volume tracking
//   stage 2 - waveform shaping and volume scaling
// Optional build macro: DDS_VOICE_VOL_RAMP_EN.
//   When defined, vol_cur slews one LSB per sample_en toward vol.
//   When undefined, vol_cur loads vol directly.
module dds_voice #(
   parameter int unsigned PHASE_WIDTH = 32,
   parameter int unsigned OUT_WIDTH   = 16,
   parameter int unsigned VOL_WIDTH   = 6,
   parameter int unsigned DUTY_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst_active_high,
   input  logic                   sample_en,
   input  logic [PHASE_WIDTH-1:0] freq_word,
   input  logic [1:0]             mode,
   input  logic [DUTY_WIDTH-1:0]  duty,
   input  logic [VOL_WIDTH-1:0]   vol,
   input  logic                   sync_in,
   output logic [OUT_WIDTH-1:0]   sample_out,
   output logic                   sample_valid,
   output logic                   wrap_out
);

   localparam int unsigned LFSR_W = 23;
   localparam int unsigned PROD_W = OUT_WIDTH + VOL_WIDTH + 1;

   // Midscale (silence) and the +/- full-scale pulse levels
   localparam logic [OUT_WIDTH-1:0] MID   = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
   localparam logic [OUT_WIDTH-1:0] POS_M = MID - OUT_WIDTH'(1);
   localparam logic [OUT_WIDTH-1:0] NEG_M = MID + OUT_WIDTH'(1);

   localparam logic [1:0] MODE_SAW   = 2'd0;
   localparam logic [1:0] MODE_PULSE = 2'd1;
   localparam logic [1:0] MODE_TRI   = 2'd2;
   localparam logic [1:0] MODE_NOISE = 2'd3;

   logic [PHASE_WIDTH-1:0] phase;
   logic [LFSR_W-1:0]      lfsr;
   logic [VOL_WIDTH-1:0]   vol_cur;
   logic                   s1_valid;

   logic [PHASE_WIDTH:0]   phase_sum_c;
   logic [LFSR_W-1:0]      lfsr_nxt_c;
   logic [VOL_WIDTH-1:0]   vol_nxt_c;

   logic [OUT_WIDTH-1:0]        p_c;
   logic [OUT_WIDTH-1:0]        duty_thr_c;
   logic [OUT_WIDTH-1:0]        tri_c;
   logic signed [OUT_WIDTH-1:0] wave_c;
   logic signed [VOL_WIDTH:0]   vol_s_c;
   logic signed [PROD_W-1:0]    prod_c;
   logic signed [PROD_W-1:0]    scaled_c;
   logic [OUT_WIDTH-1:0]        out_c;

   // Accumulator sum with carry; Fibonacci LFSR successor
   assign phase_sum_c = {1'b0, phase} + {1'b0, freq_word};
   assign lfsr_nxt_c  = {lfsr[LFSR_W-2:0], lfsr[22] ^ lfsr[17]};

`ifdef DDS_VOICE_VOL_RAMP_EN
   // Slew volume one LSB toward the target to avoid clicks
   always_comb begin
      vol_nxt_c = vol_cur;
      if (vol_cur < vol) begin
         vol_nxt_c = vol_cur + VOL_WIDTH'(1);
      end else if (vol_cur > vol) begin
         vol_nxt_c = vol_cur - VOL_WIDTH'(1);
      end
   end
`else
   // Volume follows the target directly
   assign vol_nxt_c = vol;
`endif

   // Stage 1: phase accumulation, sync, LFSR stepping on carry, volume tracking
   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         phase    <= '0;
         lfsr     <= LFSR_W'(1);
         vol_cur  <= '0;
         wrap_out <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         wrap_out <= 1'b0;
         s1_valid <= sample_en;
         if (sample_en) begin
            vol_cur <= vol_nxt_c;
            if (sync_in) begin
               phase <= '0;
            end else begin
               phase    <= phase_sum_c[PHASE_WIDTH-1:0];
               wrap_out <= phase_sum_c[PHASE_WIDTH];
               if (phase_sum_c[PHASE_WIDTH]) begin
                  lfsr <= lfsr_nxt_c;
               end
            end
         end
      end
   end

   // Stage 2 combinational: waveform select as signed sample, then volume scaling
   always_comb begin
      p_c        = phase[PHASE_WIDTH-1 -: OUT_WIDTH];
      duty_thr_c = OUT_WIDTH'(duty) << (OUT_WIDTH - DUTY_WIDTH);
      tri_c      = p_c[OUT_WIDTH-1] ? ((~p_c) << 1) : (p_c << 1);
      wave_c     = '0;
      case (mode)
         MODE_SAW:   wave_c = p_c ^ MID;
         MODE_PULSE: wave_c = (p_c < duty_thr_c) ? POS_M : NEG_M;
         MODE_TRI:   wave_c = tri_c ^ MID;
         MODE_NOISE: wave_c = lfsr[LFSR_W-1 -: OUT_WIDTH] ^ MID;
         default:    wave_c = '0;
      endcase
      vol_s_c  = {1'b0, vol_cur};
      prod_c   = PROD_W'(wave_c) * PROD_W'(vol_s_c);
      scaled_c = prod_c >>> VOL_WIDTH;
      out_c    = OUT_WIDTH'(scaled_c) + MID;
   end

   // Stage 2 registers: offset-binary sample and its valid strobe
   always_ff @(posedge clk) begin
      if (rst_active_high) begin
         sample_out   <= MID;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= s1_valid;
         if (s1_valid) begin
            sample_out <= out_c;
         end
      end
   end

endmodule

// File: tb/tb_dds_voice.sv
// Directed testbench for dds_voice at default parameters (32/16/6/8).
// Ramp-dependent expectations follow the DDS_VOICE_VOL_RAMP_EN macro.
module tb_dds_voice;

   logic        clk;
   logic        rst_active_high;
   logic        sample_en;
   logic [31:0] freq_word;
   logic [1:0]  mode;
   logic [7:0]  duty;
   logic [5:0]  vol;
   logic        sync_in;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        wrap_out;

   int checks = 0;
   int errors = 0;

   dds_voice #(
      .PHASE_WIDTH(32),
      .OUT_WIDTH  (16),
      .VOL_WIDTH  (6),
      .DUTY_WIDTH (8)
   ) dut (
      .clk             (clk),
      .rst_active_high (rst_active_high),
      .sample_en       (sample_en),
      .freq_word       (freq_word),
      .mode            (mode),
      .duty            (duty),
      .vol             (vol),
      .sync_in         (sync_in),
      .sample_out      (sample_out),
      .sample_valid    (sample_valid),
      .wrap_out        (wrap_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive inputs, take one clock edge, settle just after it
   task automatic step(input logic en, input logic sy);
      sample_en = en;
      sync_in   = sy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wraps;
      int hi_cnt;
      int lo_cnt;
      int bad;
      logic [15:0] prev;

      rst_active_high = 1'b1;
      sample_en = 1'b0;
      sync_in   = 1'b0;
      freq_word = '0;
      mode      = 2'd0;
      duty      = '0;
      vol       = '0;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("rst_out",   32'(sample_out),   32'h8000);
      chk("rst_valid", 32'(sample_valid), 32'h0);
      chk("rst_wrap",  32'(wrap_out),     32'h0);
      rst_active_high = 1'b0;

      // Saw: hold phase at 0 with sync while volume settles
      mode      = 2'd0;
      freq_word = 32'h0100_0000;
      vol       = 6'd63;
      for (int i = 0; i < 64; i++) step(1'b1, 1'b1);
      wraps = 0;
      for (int k = 1; k <= 256; k++) begin
         step(1'b1, 1'b0);
         if (wrap_out) wraps++;
         if (k == 1)   chk("saw_valid", 32'(sample_valid), 32'h1);
         if (k == 1)   chk("saw_p0000", 32'(sample_out), 32'h0200);
         if (k == 65)  chk("saw_p4000", 32'(sample_out), 32'h4100);
         if (k == 129) chk("saw_p8000", 32'(sample_out), 32'h8000);
         if (k == 193) chk("saw_pc000", 32'(sample_out), 32'hBF00);
         if (k == 256) chk("saw_wrap_at_carry", 32'(wrap_out), 32'h1);
      end
      chk("saw_wrap_count", 32'(wraps), 32'd1);

      // Pulse, duty 0x40: quarter high
      mode   = 2'd1;
      duty   = 8'h40;
      hi_cnt = 0;
      lo_cnt = 0;
      for (int j = 1; j <= 256; j++) begin
         step(1'b1, 1'b0);
         if (sample_out == 16'hFDFF) hi_cnt++;
         else if (sample_out == 16'h0200) lo_cnt++;
         if (j == 1)  chk("pulse_first", 32'(sample_out), 32'hFDFF);
         if (j == 64) chk("pulse_last_hi", 32'(sample_out), 32'hFDFF);
         if (j == 65) chk("pulse_first_lo", 32'(sample_out), 32'h0200);
      end
      chk("pulse_hi_count", 32'(hi_cnt), 32'd64);
      chk("pulse_lo_count", 32'(lo_cnt), 32'd192);

      // Triangle at quarter points
      mode = 2'd2;
      for (int j = 1; j <= 256; j++) begin
         step(1'b1, 1'b0);
         if (j == 1)   chk("tri_p0000", 32'(sample_out), 32'h0200);
         if (j == 65)  chk("tri_p4000", 32'(sample_out), 32'h8000);
         if (j == 129) chk("tri_p8000", 32'(sample_out), 32'hFDFE);
         if (j == 193) chk("tri_pc000", 32'(sample_out), 32'h7FFE);
      end

      // Sync: ignored without sample_en, resets phase and suppresses wrap with it
      mode = 2'd0;
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      chk("sync_noen_out", 32'(sample_out), 32'h4100);
      step(1'b1, 1'b0);
      chk("valid_drop", 32'(sample_valid), 32'h0);
      step(1'b0, 1'b0);
      chk("sync_noen_phase", 32'(sample_out), 32'h41FC);
      step(1'b1, 1'b1);
      for (int i = 0; i < 255; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("sync_wrap_suppressed", 32'(wrap_out), 32'h0);
      step(1'b0, 1'b0);
      chk("sync_phase_zero", 32'(sample_out), 32'h0200);
      chk("sync_valid", 32'(sample_valid), 32'h1);

      // Reset mid-stream drops the in-flight sample
      mode = 2'd3;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      rst_active_high = 1'b1;
      step(1'b1, 1'b0);
      chk("midrst_out",   32'(sample_out),   32'h8000);
      chk("midrst_valid", 32'(sample_valid), 32'h0);
      rst_active_high = 1'b0;
      step(1'b0, 1'b0);
      chk("midrst_dropped", 32'(sample_valid), 32'h0);
      step(1'b1, 1'b1);
      chk("post_rst_lat1", 32'(sample_valid), 32'h0);
      step(1'b0, 1'b0);
      chk("post_rst_lat2", 32'(sample_valid), 32'h1);

      // Noise: settle volume with sync (LFSR untouched), then half-rate wraps
      for (int i = 0; i < 63; i++) step(1'b1, 1'b1);
      chk("noise_lfsr_init", 32'(dut.lfsr), 32'h1);
      freq_word = 32'h8000_0000;
      for (int k = 1; k <= 18; k++) begin
         step(1'b1, 1'b0);
         if (k == 1)  chk("noise_wrap_t1", 32'(wrap_out), 32'h0);
         if (k == 2)  chk("noise_wrap_t2", 32'(wrap_out), 32'h1);
         if (k == 2)  chk("noise_lfsr_t2", 32'(dut.lfsr), 32'h2);
         if (k == 3)  chk("noise_lfsr_t3", 32'(dut.lfsr), 32'h2);
         if (k == 4)  chk("noise_lfsr_t4", 32'(dut.lfsr), 32'h4);
         if (k == 16) chk("noise_out_t16", 32'(sample_out), 32'h0200);
         if (k == 17) chk("noise_out_t17", 32'(sample_out), 32'h0201);
         if (k == 18) chk("noise_out_t18", 32'(sample_out), 32'h0201);
      end

      // Volume 0 -> 63 on a DC saw (phase 0, freq 0)
      rst_active_high = 1'b1;
      step(1'b0, 1'b0);
      rst_active_high = 1'b0;
      mode      = 2'd0;
      freq_word = 32'h0;
      vol       = 6'd63;
      bad       = 0;
      prev      = 16'h0;
      for (int k = 1; k <= 65; k++) begin
         step(1'b1, 1'b0);
`ifdef DDS_VOICE_VOL_RAMP_EN
         if (k >= 3 && k <= 64 && !(sample_out < prev)) bad++;
         if (k == 2)  chk("ramp_first", 32'(sample_out), 32'h7E00);
         if (k == 63) chk("ramp_62",    32'(sample_out), 32'h0400);
         if (k == 64) chk("ramp_63",    32'(sample_out), 32'h0200);
`else
         if (k >= 3 && sample_out != prev) bad++;
         if (k == 2)  chk("vol_first_full", 32'(sample_out), 32'h0200);
`endif
         if (k == 65) chk("vol_final", 32'(sample_out), 32'h0200);
         prev = sample_out;
      end
      chk("vol_monotonic", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
